// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 character-LCD controller.
// Holds op codes, panel commands, FSM encodings and small helpers.
package lcd_pkg;

    localparam logic [7:0] OP_NONE     = 8'h00;
    localparam logic [7:0] OP_REFRESH  = 8'h01;
    localparam logic [7:0] OP_CLEAR    = 8'h02;
    localparam logic [7:0] OP_RAW_CMD  = 8'h03;
    localparam logic [7:0] OP_RAW_DATA = 8'h04;
    localparam logic [7:0] OP_REINIT   = 8'hFF;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    localparam logic [7:0] INIT_FUNC  = 8'h38;
    localparam logic [7:0] INIT_DISP  = 8'h0C;
    localparam logic [7:0] INIT_CLR   = 8'h01;
    localparam logic [7:0] INIT_ENTRY = 8'h06;

    localparam logic [7:0] ROW0_BASE = 8'h00;
    localparam logic [7:0] ROW1_BASE = 8'h40;
    localparam logic [7:0] ROW2_BASE = 8'h14;
    localparam logic [7:0] ROW3_BASE = 8'h54;

    typedef enum logic [3:0] {
        ST_PWRUP   = 4'd0,
        ST_INIT    = 4'd1,
        ST_IDLE    = 4'd2,
        ST_ROWADDR = 4'd3,
        ST_CHAR    = 4'd4,
        ST_SINGLE  = 4'd5,
        ST_DONE    = 4'd6
    } state_e;

    typedef enum logic [2:0] {
        BC_IDLE, BC_SETUP, BC_EN, BC_HOLD, BC_WAIT
    } bc_phase_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return INIT_FUNC;
            2'd1:    return INIT_DISP;
            2'd2:    return INIT_CLR;
            default: return INIT_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] row_addr_cmd(input logic [1:0] row);
        case (row)
            2'd0:    return CMD_DDRAM | ROW0_BASE;
            2'd1:    return CMD_DDRAM | ROW1_BASE;
            2'd2:    return CMD_DDRAM | ROW2_BASE;
            default: return CMD_DDRAM | ROW3_BASE;
        endcase
    endfunction

    // Clear and home need the long execution delay; only as commands, not as data.
    function automatic logic needs_long(input logic rs, input logic [7:0] dat);
        return !rs && (dat == CMD_CLEAR || dat == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: 1 tick setup, EN_US ticks EN high, 1 tick hold, then post-wait.
// start is taken only in idle; done pulses for one clock when the post-wait expires.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int EN_US   = 1,
    parameter int CMD_US  = 40,
    parameter int LONG_US = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int MAX_A  = (LONG_US > CMD_US) ? LONG_US : CMD_US;
    localparam int MAX_US = (MAX_A > EN_US) ? MAX_A : EN_US;
    localparam int CW     = $clog2(MAX_US + 1);

    bc_phase_e       phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d, rs_q, rs_d, long_q, long_d;
    logic [7:0]      data_q, data_d;
    logic            expire;

    assign expire = tick && (cnt_q <= CW'(1));

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        done    = 1'b0;
        if (tick && !expire) cnt_d = cnt_q - 1'b1;
        case (phase_q)
            BC_IDLE: if (start) begin
                phase_d = BC_SETUP;
                cnt_d   = CW'(1);
                rs_d    = rs;
                data_d  = data;
                long_d  = long_wait;
            end
            BC_SETUP: if (expire) begin
                phase_d = BC_EN;
                en_d    = 1'b1;
                cnt_d   = CW'(EN_US);
            end
            BC_EN: if (expire) begin
                phase_d = BC_HOLD;
                en_d    = 1'b0;
                cnt_d   = CW'(1);
            end
            BC_HOLD: if (expire) begin
                phase_d = BC_WAIT;
                cnt_d   = long_q ? CW'(LONG_US) : CW'(CMD_US);
            end
            BC_WAIT: if (expire) begin
                phase_d = BC_IDLE;
                done    = 1'b1;
            end
            default: phase_d = BC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= BC_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    assign lcd_en   = en_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_char_ctrl.sv
// Avalon-MM character-LCD controller with shadow frame buffer and refresh/raw/init sequencing.
// Readdata has fixed latency 1; busy ops rejected into err_sticky, buffer writes always land.
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int ADDR_W   = 7,
    parameter int EN_US    = 1,
    parameter int CMD_US   = 40,
    parameter int LONG_US  = 1640,
    parameter int PWRUP_US = 15000
) (
    input  logic              csi_CLK,
    input  logic              csi_RST,
    input  logic              avs_chipselect,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              ins_IRQ,
    output logic [7:0]        coe_LCD_DATA,
    output logic              coe_LCD_RW,
    output logic              coe_LCD_EN,
    output logic              coe_LCD_RS,
    output logic              coe_LCD_BLON,
    output logic              coe_LCD_ON
);

    localparam int N   = COLS * ROWS;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(PWRUP_US + 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]   pw_cnt_q, pw_cnt_d;
    logic [1:0]      step_q, step_d, row_q, row_d;
    logic [CLW-1:0]  col_q, col_d;
    logic            inflight_q, inflight_d, init_done_q, init_done_d;
    logic            done_q, done_d, err_q, err_d, auto_q, auto_d;
    logic            irq_en_q, irq_en_d, blon_q, blon_d, sgl_rs_q, sgl_rs_d;
    logic [7:0]      op_last_q, op_last_d, raw_q, raw_d, sgl_dat_q, sgl_dat_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      buf_q [N];
    logic [7:0]      buf_d [N];

    logic            tick, busy, step_done, bc_start, bc_done;
    logic            iss_en, iss_rs;
    logic [7:0]      iss_dat, op;
    logic [IW-1:0]   chr_idx, buf_sel;
    logic [ADDR_W-2:0] buf_off;
    logic            in_buf, wr_ctrl, wr_status, wr_buf, unused_wd;

    assign tick      = (tick_cnt_q == TW'(DIV - 1));
    assign busy      = (state_q != ST_IDLE);
    assign step_done = inflight_q && bc_done;
    assign chr_idx   = IW'(32'(row_q) * COLS + 32'(col_q));
    assign buf_off   = avs_address[ADDR_W-2:0];
    assign buf_sel   = buf_off[IW-1:0];
    assign in_buf    = avs_address[ADDR_W-1] && (32'(buf_off) < N);
    assign wr_ctrl   = avs_chipselect && avs_write && (avs_address == '0);
    assign wr_status = avs_chipselect && avs_write && (avs_address == ADDR_W'(1));
    assign wr_buf    = avs_chipselect && avs_write && in_buf;
    assign op        = avs_writedata[7:0];
    assign unused_wd = ^{avs_writedata[31:25], avs_writedata[23:18]};

    always_comb begin
        state_d = state_q;       tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        pw_cnt_d = pw_cnt_q;     step_d = step_q;         row_d = row_q;
        col_d = col_q;           inflight_d = inflight_q; init_done_d = init_done_q;
        done_d = done_q;         err_d = err_q;           auto_d = auto_q;
        irq_en_d = irq_en_q;     blon_d = blon_q;         sgl_rs_d = sgl_rs_q;
        op_last_d = op_last_q;   raw_d = raw_q;           sgl_dat_d = sgl_dat_q;
        buf_d = buf_q;
        iss_en = 1'b0;  iss_rs = 1'b0;  iss_dat = '0;  bc_start = 1'b0;

        if (wr_status && avs_writedata[1]) done_d = 1'b0;
        if (wr_status && avs_writedata[2]) err_d  = 1'b0;

        case (state_q)
            ST_PWRUP: if (tick) begin
                if (pw_cnt_q == PW'(PWRUP_US - 1)) begin
                    state_d  = ST_INIT;
                    pw_cnt_d = '0;
                    step_d   = '0;
                end else begin
                    pw_cnt_d = pw_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                iss_en  = 1'b1;
                iss_dat = init_cmd(step_q);
                if (step_done) begin
                    step_d = step_q + 1'b1;
                    if (step_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_IDLE: if (auto_q) begin
                state_d = ST_ROWADDR;
                row_d   = '0;
            end
            ST_ROWADDR: begin
                iss_en  = 1'b1;
                iss_dat = row_addr_cmd(row_q);
                if (step_done) begin
                    state_d = ST_CHAR;
                    col_d   = '0;
                end
            end
            ST_CHAR: begin
                iss_en  = 1'b1;
                iss_rs  = 1'b1;
                iss_dat = buf_q[chr_idx];
                if (step_done) begin
                    col_d = col_q + 1'b1;
                    if (col_q == CLW'(COLS - 1)) begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_ROWADDR;
                        // Auto mode chains passes without passing through DONE.
                        if (row_q == 2'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = auto_q ? ST_ROWADDR : ST_DONE;
                        end
                    end
                end
            end
            ST_SINGLE: begin
                iss_en  = 1'b1;
                iss_rs  = sgl_rs_q;
                iss_dat = sgl_dat_q;
                if (step_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_PWRUP;
        endcase

        if (step_done) begin
            inflight_d = 1'b0;
        end else if (iss_en && !inflight_q && tick) begin
            bc_start   = 1'b1;
            inflight_d = 1'b1;
        end

        if (wr_ctrl) begin
            blon_d   = avs_writedata[24];
            irq_en_d = avs_writedata[17];
            auto_d   = avs_writedata[16];
            if (op != OP_NONE) begin
                if (busy || !init_done_q) begin
                    err_d = 1'b1;
                end else begin
                    op_last_d = op;
                    raw_d     = avs_writedata[15:8];
                    case (op)
                        OP_REFRESH: begin
                            state_d = ST_ROWADDR;
                            row_d   = '0;
                        end
                        OP_CLEAR: begin
                            for (int i = 0; i < N; i++) buf_d[i] = CHAR_BLANK;
                            sgl_rs_d  = 1'b0;
                            sgl_dat_d = CMD_CLEAR;
                            state_d   = ST_SINGLE;
                        end
                        OP_RAW_CMD, OP_RAW_DATA: begin
                            sgl_rs_d  = (op == OP_RAW_DATA);
                            sgl_dat_d = avs_writedata[15:8];
                            state_d   = ST_SINGLE;
                        end
                        OP_REINIT: begin
                            init_done_d = 1'b0;
                            step_d      = '0;
                            state_d     = ST_INIT;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
        end

        if (wr_buf) buf_d[buf_sel] = avs_writedata[7:0];

        rdata_d = '0;
        if (avs_chipselect && avs_read) begin
            if (in_buf)
                rdata_d = {24'b0, buf_q[buf_sel]};
            else if (avs_address == '0)
                rdata_d = {7'b0, blon_q, 6'b0, irq_en_q, auto_q, raw_q, op_last_q};
            else if (avs_address == ADDR_W'(1))
                rdata_d = {24'b0, state_q, init_done_q, err_q, done_q, busy};
        end
    end

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            state_q <= ST_PWRUP;   tick_cnt_q <= '0;    pw_cnt_q <= '0;
            step_q <= '0;          row_q <= '0;         col_q <= '0;
            inflight_q <= 1'b0;    init_done_q <= 1'b0; done_q <= 1'b0;
            err_q <= 1'b0;         auto_q <= 1'b0;      irq_en_q <= 1'b0;
            blon_q <= 1'b0;        sgl_rs_q <= 1'b0;    op_last_q <= '0;
            raw_q <= '0;           sgl_dat_q <= '0;     rdata_q <= '0;
            for (int i = 0; i < N; i++) buf_q[i] <= CHAR_BLANK;
        end else begin
            state_q <= state_d;        tick_cnt_q <= tick_cnt_d;   pw_cnt_q <= pw_cnt_d;
            step_q <= step_d;          row_q <= row_d;             col_q <= col_d;
            inflight_q <= inflight_d;  init_done_q <= init_done_d; done_q <= done_d;
            err_q <= err_d;            auto_q <= auto_d;           irq_en_q <= irq_en_d;
            blon_q <= blon_d;          sgl_rs_q <= sgl_rs_d;       op_last_q <= op_last_d;
            raw_q <= raw_d;            sgl_dat_q <= sgl_dat_d;     rdata_q <= rdata_d;
            buf_q <= buf_d;
        end
    end

    lcd_bus_cycle #(
        .EN_US   (EN_US),
        .CMD_US  (CMD_US),
        .LONG_US (LONG_US)
    ) u_bus (
        .clk       (csi_CLK),
        .rst       (csi_RST),
        .tick      (tick),
        .start     (bc_start),
        .rs        (iss_rs),
        .data      (iss_dat),
        .long_wait (needs_long(iss_rs, iss_dat)),
        .done      (bc_done),
        .lcd_en    (coe_LCD_EN),
        .lcd_rs    (coe_LCD_RS),
        .lcd_data  (coe_LCD_DATA)
    );

    assign avs_readdata = rdata_q;
    assign ins_IRQ      = done_q & irq_en_q;
    assign coe_LCD_RW   = 1'b0;
    assign coe_LCD_BLON = blon_q;
    assign coe_LCD_ON   = 1'b1;

endmodule
